// File: rtl/sync_tx_arbiter.sv
// Source-domain scheduler for a shared synchronizer crossing: round-robin
// between two requesters, then SETUP/HOLD/GAP sequencing of Unsync_bus/Unsync_enable.
module sync_tx_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  input  logic [DATA_WIDTH-1:0] REQ0_DATA,
  output logic                  REQ0_READY,
  input  logic                  REQ1_VALID,
  input  logic [DATA_WIDTH-1:0] REQ1_DATA,
  output logic                  REQ1_READY,
  output logic [DATA_WIDTH-1:0] Unsync_bus,
  output logic                  Unsync_enable,
  output logic                  grant_id,
  output logic                  busy
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            rr_last;
  logic            gnt;
  logic            hs;

  // Tie goes to the requester not served last; a lone valid always wins.
  always_comb begin
    gnt = 1'b0;
    if (REQ0_VALID && REQ1_VALID) gnt = ~rr_last;
    else if (REQ1_VALID)          gnt = 1'b1;
    REQ0_READY = (state == IDLE) && !gnt && REQ0_VALID;
    REQ1_READY = (state == IDLE) &&  gnt && REQ1_VALID;
    hs         = REQ0_READY | REQ1_READY;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (hs) state_nxt = SETUP;
      SETUP: begin
        state_nxt = HOLD;
        cnt_nxt   = CW'(HOLD_CYCLES - 1);
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_nxt   = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Enable is a flop mirroring the HOLD state so the synchronizer sees a glitch-free pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_last       <= 1'b1;
      grant_id      <= 1'b0;
      Unsync_bus    <= '0;
      Unsync_enable <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      Unsync_enable <= (state_nxt == HOLD);
      if (hs) begin
        Unsync_bus <= gnt ? REQ1_DATA : REQ0_DATA;
        grant_id   <= gnt;
        rr_last    <= gnt;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Bench for sync_tx_arbiter: three parameterizations share one stimulus stream,
// each checked by a timeline model and a queue-based transfer monitor.
module tb_sync_tx_arbiter;
  localparam int N = 3;

  typedef struct packed {
    logic [7:0]  data;
    logic        id;
    int unsigned t;
  } exp_t;

  logic             gclk = 1'b0;
  logic             grst_n = 1'b0;
  logic             v0 = 1'b0, v1 = 1'b0;
  logic [7:0]       d0 = 8'h00, d1 = 8'h00;
  logic [N-1:0]     rdy0, rdy1, en, gid, bsy;
  logic [N-1:0][7:0] bus;
  int               n_cmp = 0, n_err = 0;

  always #5 gclk = ~gclk;

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int HK = (k == 0) ? 3 : ((k == 1) ? 1 : 5);
    localparam int GK = (k == 0) ? 2 : ((k == 1) ? 1 : 4);

    exp_t        q[$];
    int unsigned e = 0, t = 0, nf = 0;
    bit          has_t = 1'b0, last_hs0 = 1'b0, last_hs1 = 1'b0;
    logic [7:0]  mbus = 8'h00;
    logic        mgid = 1'b0, mptr = 1'b1;

    sync_tx_arbiter #(.DATA_WIDTH(8), .HOLD_CYCLES(HK), .GAP_CYCLES(GK)) dut (
      .CLK(gclk), .RST(grst_n),
      .REQ0_VALID(v0), .REQ0_DATA(d0), .REQ0_READY(rdy0[k]),
      .REQ1_VALID(v1), .REQ1_DATA(d1), .REQ1_READY(rdy1[k]),
      .Unsync_bus(bus[k]), .Unsync_enable(en[k]),
      .grant_id(gid[k]), .busy(bsy[k])
    );

    // Timeline model: a handshake at edge t owns edges t..t+1+H+G; enable covers edges t+1..t+H.
    initial begin : model
      logic g, r0, r1;
      forever begin
        @(negedge gclk);
        #1;
        e++;
        if (!grst_n) begin
          has_t = 1'b0; nf = 0; mbus = 8'h00; mgid = 1'b0; mptr = 1'b1;
          q.delete();
        end
        chk1($sformatf("d%0d_enable", k), en[k], has_t && e >= t + 1 && e <= t + HK);
        chk1($sformatf("d%0d_busy", k), bsy[k], has_t && e >= t && e <= t + HK + GK);
        chk8($sformatf("d%0d_bus", k), bus[k], mbus);
        chk1($sformatf("d%0d_grant_id", k), gid[k], mgid);
        g  = (v0 && v1) ? ~mptr : v1;
        r0 = (e + 1 >= nf) && !g && v0;
        r1 = (e + 1 >= nf) &&  g && v1;
        chk1($sformatf("d%0d_ready0", k), rdy0[k], r0);
        chk1($sformatf("d%0d_ready1", k), rdy1[k], r1);
        last_hs0 = grst_n && r0;
        last_hs1 = grst_n && r1;
        if (grst_n && (r0 || r1)) begin
          t = e + 1; has_t = 1'b1; nf = t + 2 + HK + GK;
          mbus = g ? d1 : d0; mgid = g; mptr = g;
          q.push_back('{data: mbus, id: g, t: t});
        end
      end
    end

    initial begin : mon
      exp_t cur;
      bit   act, prev;
      int   len;
      act = 1'b0; prev = 1'b0; len = 0;
      forever begin
        @(negedge gclk);
        #2;
        if (!grst_n) begin
          act = 1'b0; prev = 1'b0;
        end else begin
          if (en[k] && !prev) begin
            chk1($sformatf("d%0d_rise_expected", k), q.size() != 0, 1'b1);
            if (q.size() != 0) begin
              cur = q.pop_front();
              chk8($sformatf("d%0d_xfer_data", k), bus[k], cur.data);
              chk1($sformatf("d%0d_xfer_id", k), gid[k], cur.id);
              chkn($sformatf("d%0d_rise_time", k), int'(e), int'(cur.t) + 1);
              act = 1'b1; len = 0;
            end
          end
          if (en[k]) len++;
          else if (prev && act) begin
            chkn($sformatf("d%0d_enable_width", k), len, HK);
            act = 1'b0;
          end
          prev = en[k];
        end
      end
    end
  end

  task automatic cyc(input logic a0, input logic [7:0] b0, input logic a1, input logic [7:0] b1);
    @(negedge gclk);
    v0 = a0; d0 = b0; v1 = a1; d1 = b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    int n;
    idle(4);
    @(negedge gclk);
    grst_n = 1'b1;

    // single REQ0 transfer of 0xA5
    cyc(1'b1, 8'hA5, 1'b0, 8'h00);
    idle(12);

    // continuous tie: alternating 0x11 / 0x22
    for (int i = 0; i < 30; i++) cyc(1'b1, 8'h11, 1'b1, 8'h22);
    idle(12);

    // REQ1 only, back-to-back 1,2,3 as paced by the default-parameter instance
    n = 1;
    for (int i = 0; i < 40 && n <= 3; i++) begin
      @(negedge gclk);
      if (g_dut[0].last_hs1) n++;
      v0 = 1'b0; v1 = (n <= 3); d1 = 8'(n);
    end
    chkn("req1_seq_done", n, 4);
    idle(12);

    // REQ0 raised while a REQ1 transfer is in HOLD
    cyc(1'b0, 8'h00, 1'b1, 8'h5A);
    idle(2);
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'h77, 1'b0, 8'h00);
    idle(12);

    // async reset in the second HOLD cycle, then a clean 0x3C transfer
    cyc(1'b1, 8'h99, 1'b0, 8'h00);
    idle(3);
    #3 grst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk1("rst_mid_enable", en[k], 1'b0);
      chk8("rst_mid_bus", bus[k], 8'h00);
      chk1("rst_mid_busy", bsy[k], 1'b0);
    end
    idle(1);
    @(negedge gclk);
    grst_n = 1'b1;
    cyc(1'b1, 8'h3C, 1'b0, 8'h00);
    idle(12);

    // random traffic, valids may drop before acceptance
    for (int i = 0; i < 500; i++)
      cyc(($urandom % 3) != 0, 8'($urandom), ($urandom % 3) != 0, 8'($urandom));
    idle(20);

    chkn("d0_queue_drained", g_dut[0].q.size(), 0);
    chkn("d1_queue_drained", g_dut[1].q.size(), 0);
    chkn("d2_queue_drained", g_dut[2].q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
